// File: rtl/nabp_image_ram_responder.sv
// nabp_image_ram_responder: fetches one image line from RAM through the image addresser and feeds it to the PE chain
module nabp_image_ram_responder #(
  parameter int ADDR_W           = 12,
  parameter int DATA_W           = 8,
  parameter int NO_OF_PARTITIONS = 4,
  parameter int LINE_LEN         = 256,
  parameter int IMAGE_WORDS      = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ir_kick,
  output logic              ir_enable,
  input  logic [ADDR_W-1:0] ir_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pe_ready,
  output logic              pe_valid,
  output logic [DATA_W-1:0] pe_data,
  output logic              addr_err
);
  localparam int CW = $clog2(LINE_LEN + 1);
  typedef enum logic [2:0] {IDLE, KICK, DELAY, STREAM, DRAIN} state_t;
  state_t            st_q, st_d;
  logic [3:0]        dly_q;
  logic [CW-1:0]     cnt_q;
  logic              drn_q, busy_q, kick_q, done_q, v1_q, pv_q, err_q;
  logic [DATA_W-1:0] pd_q;
  assign ir_enable = st_q == STREAM && pe_ready;
  assign mem_rd_en = ir_enable;
  assign mem_addr  = ir_enable ? ir_addr : '0;
  assign busy      = busy_q;
  assign ir_kick   = kick_q;
  assign done      = done_q;
  assign pe_valid  = pv_q;
  assign pe_data   = pd_q;
  assign addr_err  = err_q;
  // next-state decode; unknown encodings fall back to IDLE
  always_comb begin
    st_d = IDLE;
    case (st_q)
      IDLE:    st_d = start ? KICK : IDLE;
      KICK:    st_d = DELAY;
      DELAY:   st_d = dly_q == '0 ? STREAM : DELAY;
      STREAM:  st_d = (mem_rd_en && cnt_q == CW'(LINE_LEN - 1)) ? DRAIN : STREAM;
      DRAIN:   st_d = drn_q ? IDLE : DRAIN;
      default: st_d = IDLE;
    endcase
  end
  // state, counters, registered status outputs and the two-stage read pipeline
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      dly_q  <= '0;
      cnt_q  <= '0;
      drn_q  <= 1'b0;
      busy_q <= 1'b0;
      kick_q <= 1'b0;
      done_q <= 1'b0;
      v1_q   <= 1'b0;
      pv_q   <= 1'b0;
      pd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      busy_q <= st_d != IDLE;
      kick_q <= st_d == KICK;
      done_q <= st_q == DRAIN && !drn_q;
      drn_q  <= st_q == DRAIN;
      dly_q  <= st_q == KICK ? 4'(NO_OF_PARTITIONS - 1) : st_q == DELAY ? dly_q - 4'd1 : dly_q;
      cnt_q  <= st_q == KICK ? '0 : mem_rd_en ? cnt_q + CW'(1) : cnt_q;
      v1_q   <= mem_rd_en;
      pv_q   <= v1_q;
      pd_q   <= mem_rdata;
      err_q  <= err_q | (mem_rd_en && 32'(ir_addr) >= IMAGE_WORDS);
    end
  end
endmodule

// File: tb/tb_nabp_image_ram_responder.sv
// tb_nabp_image_ram_responder: scoreboard bench for a default-size line DUT and a one-word line DUT
module tb_nabp_image_ram_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  start, busy, done, kick, en, rd, rdy, pv, err;
  logic [12:0] ia[2], ma[2];
  logic [11:0] mb;
  logic [7:0]  rdat[2], pd[2];
  int          base[2], n_rd[2], n_pv[2], n_done[2], n_kick[2];
  int          t_kick[2], t_rd0[2], t_rd1[2], t_pv0[2], t_pv1[2], t_done[2], t_err[2];
  logic [1:0]  f_rd, f_pv, err_prev;
  logic [7:0]  expa[$], expb[$];
  int          cyc = 0, n_chk = 0, n_pass = 0;
  int          c0, s_done, s_rd, s_pv, s_kick;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nabp_image_ram_responder #(.ADDR_W(13)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .ir_kick(kick[0]), .ir_enable(en[0]), .ir_addr(ia[0]), .mem_rd_en(rd[0]),
    .mem_addr(ma[0]), .mem_rdata(rdat[0]), .pe_ready(rdy[0]), .pe_valid(pv[0]),
    .pe_data(pd[0]), .addr_err(err[0]));

  nabp_image_ram_responder #(.LINE_LEN(1), .NO_OF_PARTITIONS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .ir_kick(kick[1]), .ir_enable(en[1]), .ir_addr(ia[1][11:0]), .mem_rd_en(rd[1]),
    .mem_addr(mb), .mem_rdata(rdat[1]), .pe_ready(rdy[1]), .pe_valid(pv[1]),
    .pe_data(pd[1]), .addr_err(err[1]));
  assign ma[1] = {1'b0, mb};

  function automatic logic [7:0] f(input int a);
    return 8'(a * 7 + 3);
  endfunction

  task automatic chk(input string nm, input int d, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d got %0d expected %0d", nm, d, got, exp);
  endtask

  // image addresser and RAM models: address restarts on kick, steps on enable; RAM answers one cycle later
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (kick[d]) ia[d] <= 13'(base[d]);
      else if (en[d]) ia[d] <= ia[d] + 13'd1;
      rdat[d] <= f(int'(ma[d]));
    end

  // monitor: event timing bookkeeping and scoreboard pops on every pe_valid
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (kick[d]) begin n_kick[d]++; t_kick[d] = cyc; f_rd[d] = 1'b1; f_pv[d] = 1'b1; end
      if (rd[d]) begin
        n_rd[d]++; t_rd1[d] = cyc;
        if (f_rd[d]) begin t_rd0[d] = cyc; f_rd[d] = 1'b0; end
        chk("mem_addr", d, int'(ma[d]), int'(ia[d]));
      end
      if (pv[d]) begin
        n_pv[d]++; t_pv1[d] = cyc;
        if (f_pv[d]) begin t_pv0[d] = cyc; f_pv[d] = 1'b0; end
        if ((d == 0 ? expa.size() : expb.size()) == 0) chk("pe_valid_unexpected", d, 1, 0);
        else if (d == 0) chk("pe_data", d, int'(pd[0]), int'(expa.pop_front()));
        else chk("pe_data", d, int'(pd[1]), int'(expb.pop_front()));
      end
      if (done[d]) begin n_done[d]++; t_done[d] = cyc; end
      if (err[d] && !err_prev[d]) t_err[d] = cyc;
      err_prev[d] = err[d];
    end

  task automatic line(input int d, input int b, input int len, input int drop, input int x0, input int x1, input int dur);
    @(posedge clk); #2;
    base[d] = b;
    for (int k = 0; k < len; k++) if (d == 0) expa.push_back(f(b + k)); else expb.push_back(f(b + k));
    s_done = n_done[d]; s_rd = n_rd[d]; s_pv = n_pv[d]; s_kick = n_kick[d];
    c0 = cyc;
    start[d] = 1'b1;
    for (int r = 1; r <= dur; r++) begin
      @(posedge clk); #2;
      start[d] = r == x0 || r == x1;
      rdy[d] = !(drop > 0 && r >= drop && r < drop + 3);
    end
    @(negedge clk);
  endtask

  task automatic tcheck(input int d, input int fr, input int lr, input int nrd, input int dn);
    chk("kick_cycle", d, t_kick[d] - c0, 1);
    chk("kick_count", d, n_kick[d] - s_kick, 1);
    chk("first_read_cycle", d, t_rd0[d] - c0, fr);
    chk("last_read_cycle", d, t_rd1[d] - c0, lr);
    chk("read_count", d, n_rd[d] - s_rd, nrd);
    chk("pe_valid_count", d, n_pv[d] - s_pv, nrd);
    chk("first_pe_valid_cycle", d, t_pv0[d] - c0, fr + 2);
    chk("last_pe_valid_cycle", d, t_pv1[d] - c0, lr + 2);
    chk("done_cycle", d, t_done[d] - c0, dn);
    chk("done_count", d, n_done[d] - s_done, 1);
    chk("busy_after_line", d, int'(busy[d]), 0);
    chk("scoreboard_left", d, d == 0 ? expa.size() : expb.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = '0; rdy = 2'b11; base = '{0, 0};
    n_rd = '{0, 0}; n_pv = '{0, 0}; n_done = '{0, 0}; n_kick = '{0, 0};
    t_kick = '{0, 0}; t_rd0 = '{0, 0}; t_rd1 = '{0, 0}; t_pv0 = '{0, 0}; t_pv1 = '{0, 0};
    t_done = '{0, 0}; t_err = '{0, 0}; f_rd = '0; f_pv = '0; err_prev = '0;
    ia[0] = '0; ia[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_outputs", d, int'({busy[d], done[d], kick[d], en[d], rd[d], ma[d], pv[d], pd[d], err[d]}), 0);
    @(posedge clk); #2; reset_n = 1'b1;
    // full default line, pe_ready held high
    line(0, 0, 256, 0, 0, 0, 270);
    tcheck(0, 6, 261, 256, 263);
    chk("addr_err_clean", 0, int'(err[0]), 0);
    // three stalled cycles mid-stream
    line(0, 0, 256, 20, 0, 0, 270);
    tcheck(0, 6, 264, 256, 266);
    // start pulses during DELAY and in the done cycle are ignored
    line(0, 0, 256, 0, 3, 263, 270);
    tcheck(0, 6, 261, 256, 263);
    // last issued address lands exactly on IMAGE_WORDS
    line(0, 3841, 256, 0, 0, 0, 270);
    tcheck(0, 6, 261, 256, 263);
    chk("addr_err_rise_cycle", 0, t_err[0] - c0, 262);
    chk("addr_err_sticky", 0, int'(err[0]), 1);
    // one-word line with a single-cycle delay
    line(1, 100, 1, 0, 0, 0, 10);
    tcheck(1, 3, 3, 1, 5);
    // reset in the 10th STREAM cycle aborts the line
    @(posedge clk); #2;
    base[0] = 0;
    for (int k = 0; k < 256; k++) expa.push_back(f(k));
    s_done = n_done[0]; s_pv = n_pv[0]; c0 = cyc; start[0] = 1'b1;
    for (int r = 1; r <= 15; r++) begin @(posedge clk); #2; start[0] = 1'b0; end
    reset_n = 1'b0;
    @(posedge clk); #2; reset_n = 1'b1; expa.delete();
    @(negedge clk);
    chk("abort_outputs", 0, int'({busy[0], done[0], kick[0], en[0], rd[0], ma[0], pv[0], pd[0], err[0]}), 0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", 0, n_done[0] - s_done, 0);
    chk("abort_delivered", 0, n_pv[0] - s_pv, 8);
    line(0, 0, 256, 0, 0, 0, 270);
    tcheck(0, 6, 261, 256, 263);
    chk("addr_err_after_reset", 0, int'(err[0]), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nabp_image_ram_responder.md
NABP_IMAGE_RAM_RESPONDER -- requirements
Module: nabp_image_ram_responder

Interface
REQ-001 Parameter ADDR_W, default 12, width of ir_addr and mem_addr.
REQ-002 Parameter DATA_W, default 8, width of mem_rdata and pe_data.
REQ-003 Parameter NO_OF_PARTITIONS, default 4, addresser delay length in cycles; legal range is 1..16.
REQ-004 Parameter LINE_LEN, default 256, number of addresses per line; legal range is 1..2^ADDR_W.
REQ-005 Parameter IMAGE_WORDS, default 4096, number of valid RAM words.
REQ-006 Port clk, input, 1, rising-edge clock.
REQ-007 Port reset_n, input, 1, synchronous active-low reset.
REQ-008 Port start, input, 1, one-cycle request to fetch one line.
REQ-009 Port busy, output, 1, high in every state except IDLE.
REQ-010 Port done, output, 1, one-cycle pulse when the line is fully delivered.
REQ-011 Port ir_kick, output, 1, one-cycle kick to the image addresser.
REQ-012 Port ir_enable, output, 1, addresser advance enable.
REQ-013 Port ir_addr, input, ADDR_W, address driven by the image addresser.
REQ-014 Port mem_rd_en, output, 1, RAM read strobe.
REQ-015 Port mem_addr, output, ADDR_W, RAM read address.
REQ-016 Port mem_rdata, input, DATA_W, RAM data, valid exactly 1 cycle after mem_rd_en.
REQ-017 Port pe_ready, input, 1, PE domino chain can accept new feed values.
REQ-018 Port pe_valid, output, 1, pe_data valid this cycle.
REQ-019 Port pe_data, output, DATA_W, feed value to the PE domino chain.
REQ-020 Port addr_err, output, 1, sticky out-of-range address flag.

Function
REQ-021 The block SHALL implement the states IDLE, KICK, DELAY, STREAM and DRAIN.
REQ-022 IDLE SHALL go to KICK on start=1; start SHALL be ignored in every other state.
REQ-023 KICK SHALL last exactly 1 cycle with ir_kick=1, then go to DELAY with the delay counter loaded to NO_OF_PARTITIONS-1.
REQ-024 DELAY SHALL decrement the counter each cycle and go to STREAM in the cycle after the counter reads 0, so DELAY lasts NO_OF_PARTITIONS cycles.
REQ-025 In STREAM, ir_enable SHALL equal pe_ready, and ir_enable SHALL be 0 in all other states.
REQ-026 In STREAM, when ir_enable=1, the block SHALL assert mem_rd_en=1 combinationally, drive mem_addr=ir_addr, and increment the issued count.
REQ-027 When ir_enable=0 in STREAM, mem_rd_en SHALL be 0 and the issued count SHALL hold.
REQ-028 STREAM SHALL go to DRAIN in the cycle after the issue that makes the count equal LINE_LEN; LINE_LEN=1 SHALL give a single-cycle STREAM when pe_ready=1.
REQ-029 pe_valid SHALL equal mem_rd_en delayed by 2 cycles.
REQ-030 pe_data SHALL be mem_rdata registered once, giving a total latency of 2 cycles from ir_addr to pe_data.
REQ-031 Reads already issued SHALL be delivered even when pe_ready=0; the PE chain absorbs up to 2 in-flight values.
REQ-032 DRAIN SHALL last 2 cycles, and done SHALL pulse in the last DRAIN cycle, coinciding with the final pe_valid.
REQ-033 The next state after DRAIN SHALL be IDLE; a start in the done cycle SHALL be ignored.
REQ-034 An issued ir_addr >= IMAGE_WORDS SHALL set addr_err=1, the read SHALL still be issued, and addr_err SHALL be cleared only by reset.
REQ-035 The issued count SHALL be ceil(log2(LINE_LEN+1)) bits wide and SHALL never wrap within a line.
REQ-036 An encoding outside the five states SHALL return the block to IDLE on the next cycle.

Reset
REQ-037 When reset_n=0 at a clock edge, the block SHALL enter IDLE and clear all counters and the pipeline valids.
REQ-038 The reset value of every output SHALL be 0, including busy, done, ir_kick, ir_enable, mem_rd_en, mem_addr, pe_valid, pe_data and addr_err.
REQ-039 Reset asserted mid-STREAM SHALL abort the line with no done pulse, and pe_valid SHALL be 0 from the next cycle.

Verification
REQ-040 Scenario: defaults, start at cycle 0, pe_ready=1 -> ir_kick at cycle 1, DELAY cycles 2-5, 256 reads in cycles 6-261, pe_valid in cycles 8-263, done at cycle 263.
REQ-041 Scenario: pe_ready=0 for 3 cycles mid-STREAM -> exactly 3 cycles with mem_rd_en=0, 2 in-flight pe_valid still delivered, done 3 cycles later than in REQ-040.
REQ-042 Scenario: LINE_LEN=1, NO_OF_PARTITIONS=1 -> KICK, 1 DELAY cycle, 1 read, DRAIN, done 5 cycles after start, pe_data=RAM[ir_addr].
REQ-043 Scenario: ir_addr=4096 issued once -> addr_err=1 from the next cycle, line still completes, addr_err still 1 after done.
REQ-044 Scenario: start pulsed during DELAY and in the done cycle -> ignored, exactly one done pulse, busy=0 after DRAIN.
REQ-045 Scenario: reset_n=0 at the 10th STREAM cycle -> all outputs 0 on the next cycle, no done pulse, a new start is accepted normally.
